// File: rtl/neuron_sequencer.sv
// neuron_sequencer: owns one neuron's weight memory port. Loads a weight set
// word by word, then runs a MAC pass over numWeights activations, adds a bias
// and emits one saturated fixed-point result.
module neuron_sequencer #(
    parameter int numWeights   = 16,
    parameter int addressWidth = 4,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8,
    parameter int accWidth     = 36
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    loadStart,
    input  logic                    loadValid,
    input  logic [dataWidth-1:0]    loadData,
    output logic                    loadReady,
    output logic                    loadDone,
    input  logic                    start,
    input  logic [dataWidth-1:0]    biasIn,
    input  logic                    inValid,
    input  logic [dataWidth-1:0]    inData,
    output logic                    inReady,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [dataWidth-1:0]    outData,
    output logic                    busy,
    output logic                    memReadEn,
    output logic                    memWriteEn,
    output logic [addressWidth-1:0] memAddr,
    output logic [dataWidth-1:0]    memDataIn,
    input  logic [dataWidth-1:0]    memDataOut
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeights - 1);
    // Saturation bounds of the output format, expressed at accumulator width.
    localparam logic signed [accWidth-1:0] SAT_MAX =
        {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [accWidth-1:0] SAT_MIN =
        {{(accWidth-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

    state_t                        state_q;
    logic [addressWidth-1:0]       cnt_q;
    logic signed [accWidth-1:0]    acc_q;
    logic [dataWidth-1:0]          out_q;
    logic                          loadDone_q;

    logic                          cnt_last;
    logic signed [2*dataWidth-1:0] prod;
    logic signed [accWidth-1:0]    acc_d;
    logic signed [accWidth-1:0]    bias_init;
    logic signed [accWidth-1:0]    scaled;
    logic [dataWidth-1:0]          sat_d;

    assign cnt_last  = (cnt_q == LAST);
    assign prod      = $signed(memDataOut) * $signed(inData);
    assign acc_d     = acc_q + {{(accWidth-2*dataWidth){prod[2*dataWidth-1]}}, prod};
    assign bias_init = {{(accWidth-dataWidth){biasIn[dataWidth-1]}}, biasIn} <<< fracBits;
    assign scaled    = acc_d >>> fracBits;

    // Clamp the final sum (including the last product) into the output format.
    always_comb begin
        sat_d = scaled[dataWidth-1:0];
        if (scaled > SAT_MAX)
            sat_d = {1'b0, {(dataWidth-1){1'b1}}};
        else if (scaled < SAT_MIN)
            sat_d = {1'b1, {(dataWidth-1){1'b0}}};
    end

    // Port handshakes and memory controls decode directly from the state register.
    assign loadReady  = (state_q == LOAD);
    assign inReady    = (state_q == RUN);
    assign outValid   = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign memWriteEn = (state_q == LOAD) && loadValid;
    assign memReadEn  = (state_q == RUN);
    assign memAddr    = (state_q == LOAD || state_q == RUN) ? cnt_q : '0;
    assign memDataIn  = memWriteEn ? loadData : '0;
    assign outData    = out_q;
    assign loadDone   = loadDone_q;

    // Sequencer FSM: address counter, accumulator, result and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            loadDone_q <= 1'b0;
        end else begin
            loadDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // loadStart has priority; a simultaneous start is dropped.
                    if (loadStart) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end else if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        acc_q   <= bias_init;
                    end
                end
                LOAD: begin
                    if (loadValid) begin
                        if (cnt_last) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            loadDone_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + addressWidth'(1);
                        end
                    end
                end
                RUN: begin
                    if (inValid) begin
                        acc_q <= acc_d;
                        if (cnt_last) begin
                            state_q <= OUT;
                            cnt_q   <= '0;
                            out_q   <= sat_d;
                        end else begin
                            cnt_q <= cnt_q + addressWidth'(1);
                        end
                    end
                end
                OUT: begin
                    if (outReady) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a queue-based result scoreboard.
module tb_neuron_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        loadStart = 1'b0, loadValid = 1'b0, start = 1'b0;
    logic        inValid = 1'b0, outReady = 1'b1;
    logic [15:0] loadData = '0, biasIn = '0, inData = '0;
    logic        loadReady, loadDone, inReady, outValid, busy;
    logic        memReadEn, memWriteEn;
    logic [3:0]  memAddr;
    logic [15:0] memDataIn, memDataOut, outData;

    logic [15:0] mem [16];
    logic [15:0] exp_q [$];
    int total = 0;
    int bad = 0;

    neuron_sequencer dut (
        .clk(clk), .rstn(rstn),
        .loadStart(loadStart), .loadValid(loadValid), .loadData(loadData),
        .loadReady(loadReady), .loadDone(loadDone),
        .start(start), .biasIn(biasIn),
        .inValid(inValid), .inData(inData), .inReady(inReady),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .busy(busy), .memReadEn(memReadEn), .memWriteEn(memWriteEn),
        .memAddr(memAddr), .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    always #5 clk = ~clk;

    // Weight memory: synchronous write, combinational read.
    always @(posedge clk) if (memWriteEn) mem[memAddr] <= memDataIn;
    assign memDataOut = mem[memAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every accepted result pops one expected value.
    always @(negedge clk) begin
        if (rstn && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL result: got %0h expected nothing", outData);
            end else begin
                check("result", {16'h0, outData}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {7'h0, loadReady, loadDone, inReady, outValid, busy, memReadEn,
                memWriteEn, memAddr, memDataIn} ^ {16'h0, outData};
    endfunction

    task automatic do_load(input logic [15:0] w);
        loadStart = 1; tick(); loadStart = 0;
        loadValid = 1; loadData = w;
        for (int i = 0; i < 16; i++) tick();
        loadValid = 0; loadData = 0;
        @(negedge clk);
        check("loadDone pulse", {31'h0, loadDone}, 1);
        check("load back idle", {31'h0, busy}, 0);
        tick();
        @(negedge clk);
        check("loadDone once", {31'h0, loadDone}, 0);
        tick();
    endtask

    task automatic do_run(input logic [15:0] bias, input logic [15:0] x,
                          input logic [15:0] e, input bit gaps, input int hold);
        int acc = 0;
        int guard = 0;
        logic [15:0] v;
        outReady = (hold == 0);
        start = 1; biasIn = bias; exp_q.push_back(e);
        tick(); start = 0;
        while (acc < 16 && guard < 400) begin
            inValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            inData  = inValid ? x : 16'h7FFF;
            if (inValid) acc++;
            guard++;
            if (!gaps && acc == 16) begin
                @(negedge clk);
                check("outValid early", {31'h0, outValid}, 0);
            end
            tick();
        end
        inValid = 0; inData = 0;
        if (!gaps && hold == 0) begin
            @(negedge clk);
            check("latency outValid", {31'h0, outValid}, 1);
        end
        guard = 0;
        while (!outValid && guard < 50) begin tick(); guard++; end
        if (!outValid) begin
            total++; bad++;
            $display("FAIL outValid timeout: got 0 expected 1");
        end
        if (hold > 0) begin
            v = outData;
            for (int i = 0; i < hold; i++) begin
                start = (i == 2);
                @(negedge clk);
                check("hold valid", {31'h0, outValid}, 1);
                check("hold data", {16'h0, outData}, {16'h0, v});
                tick();
            end
            start = 0;
            outReady = 1;
        end
        tick();
        @(negedge clk);
        check("idle after out", {30'h0, busy, outValid}, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #3;
        check("reset outputs", all_outs(), 0);
        #10; rstn = 1;
        tick();

        // 16 x 1.0 * 1.0 + 0 = 16.0
        do_load(16'h0100);
        do_run(16'h0000, 16'h0100, 16'h1000, 0, 0);

        // 16 x 1.0 * 0.5 + 3.0 = 11.0, input gaps and 5 cycles of backpressure
        do_run(16'h0300, 16'h0080, 16'h0B00, 1, 5);

        // Reset after 7 accepted inputs
        start = 1; biasIn = 16'h0000; tick(); start = 0;
        inValid = 1; inData = 16'h0100;
        for (int i = 0; i < 7; i++) tick();
        inValid = 0;
        rstn = 0; #2;
        check("mid-run reset outputs", all_outs(), 0);
        tick(); tick();
        rstn = 1;
        @(negedge clk);
        check("after release outputs", all_outs(), 0);
        tick();
        // 16 x 1.0 * 0.25 - 1.0 = 3.0 from retained weights
        do_run(16'hFF00, 16'h0040, 16'h0300, 0, 0);

        // 16 x -1.0 * 2.0 + 1.0 = -31.0
        do_load(16'hFF00);
        do_run(16'h0100, 16'h0200, 16'hE100, 0, 0);

        // Saturation both ways
        do_load(16'h7FFF);
        do_run(16'h0000, 16'h7FFF, 16'h7FFF, 0, 0);
        do_run(16'h0000, 16'h8000, 16'h8000, 0, 0);

        // Simultaneous loadStart and start: LOAD wins
        loadStart = 1; start = 1; biasIn = 16'h1234; tick();
        loadStart = 0; start = 0;
        @(negedge clk);
        check("both cmd loadReady", {31'h0, loadReady}, 1);
        begin
            int n = 0;
            int guard = 0;
            tick();
            while (n < 16 && guard < 200) begin
                loadValid = ($urandom_range(0, 3) != 0);
                loadData = 16'h0100;
                @(negedge clk);
                check("writeEn follows valid", {31'h0, memWriteEn}, {31'h0, loadValid});
                check("inReady low in load", {31'h0, inReady}, 0);
                if (loadValid) n++;
                guard++;
                tick();
            end
            loadValid = 0;
            @(negedge clk);
            check("both cmd loadDone", {31'h0, loadDone}, 1);
            tick();
        end
        do_run(16'h0000, 16'h0100, 16'h1000, 0, 0);

        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
